// File: rtl/rs_encoder_7_3.sv
// Systematic RS(7,3) encoder over GF(2^3) (x^3+x+1).
// Serial LFSR: one message symbol per clock, m2 first; codeword = {m2,m1,m0,p3,p2,p1,p0}.
module rs_encoder_7_3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  message,
  output logic        busy,
  output logic        valid,
  output logic [20:0] codeword
);

  localparam int SYM_W = 3;
  localparam int N     = 7;
  localparam int K     = 3;
  localparam int MSG_W = K * SYM_W;
  localparam int CW_W  = N * SYM_W;
  localparam logic [3:0] PRIM_POLY = 4'b1011;

  // Generator coefficients, index = power of x: g0, g1, g2, g3.
  localparam logic [SYM_W-1:0] G [4] = '{3'b011, 3'b010, 3'b001, 3'b011};

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // GF(2^3) multiply: carry-less product, then fold bits 4 and 3 back with the field polynomial.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [4:0] prod;
    prod = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) prod = prod ^ ({2'b00, a} << i);
    end
    if (prod[4]) prod = prod ^ {PRIM_POLY, 1'b0};
    if (prod[3]) prod = prod ^ {1'b0, PRIM_POLY};
    return prod[SYM_W-1:0];
  endfunction

  state_t           r_state, w_state_next;
  logic [MSG_W-1:0] r_msg, w_msg_next;
  logic [1:0]       r_cnt, w_cnt_next;
  logic [SYM_W-1:0] r_p [4];
  logic [SYM_W-1:0] w_p_next [4];
  logic [SYM_W-1:0] w_shift [4];
  logic [SYM_W-1:0] w_gmul [4];
  logic             r_valid, w_valid_next;
  logic [CW_W-1:0]  r_codeword, w_codeword_next;
  logic [SYM_W-1:0] w_sym;
  logic [SYM_W-1:0] w_fb;

  // Select the message symbol for this shift: m2, m1, then m0.
  always_comb begin
    case (r_cnt)
      2'd0:    w_sym = r_msg[8:6];
      2'd1:    w_sym = r_msg[5:3];
      default: w_sym = r_msg[2:0];
    endcase
  end

  assign w_fb = w_sym ^ r_p[3];

  // Feedback times each generator coefficient, and the shifted parity register contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      assign w_gmul[gi] = gf_mul(G[gi], w_fb);
      if (gi == 0) begin : g_low
        assign w_shift[gi] = w_gmul[gi];
      end else begin : g_up
        assign w_shift[gi] = r_p[gi-1] ^ w_gmul[gi];
      end
    end
  endgenerate

  // Next-state and datapath decode; everything holds unless the state says otherwise.
  always_comb begin
    w_state_next    = r_state;
    w_msg_next      = r_msg;
    w_cnt_next      = r_cnt;
    w_p_next        = r_p;
    w_valid_next    = 1'b0;
    w_codeword_next = r_codeword;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_msg_next   = message;
          w_p_next     = '{default: '0};
          w_cnt_next   = 2'd0;
          w_state_next = S_SHIFT;
        end
      end
      default: begin
        w_p_next   = w_shift;
        w_cnt_next = r_cnt + 2'd1;
        if (r_cnt == 2'd2) begin
          // Codeword is loaded only from the final parity so it never shows partial results.
          w_codeword_next = {r_msg, w_shift[3], w_shift[2], w_shift[1], w_shift[0]};
          w_valid_next    = 1'b1;
          w_state_next    = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any encode in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_msg      <= '0;
      r_cnt      <= 2'd0;
      r_p        <= '{default: '0};
      r_valid    <= 1'b0;
      r_codeword <= '0;
    end else begin
      r_state    <= w_state_next;
      r_msg      <= w_msg_next;
      r_cnt      <= w_cnt_next;
      r_p        <= w_p_next;
      r_valid    <= w_valid_next;
      r_codeword <= w_codeword_next;
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign valid    = r_valid;
  assign codeword = r_codeword;

endmodule

// File: tb/tb_rs_encoder_7_3.sv
// Directed bench for rs_encoder_7_3: reset, single encode, ignore-while-busy,
// mid-encode reset, reset+enable, linearity, and all 512 messages back-to-back.
module tb_rs_encoder_7_3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [8:0]  message;
  logic        busy;
  logic        valid;
  logic [20:0] codeword;

  int n_tests = 0;
  int n_fail  = 0;

  rs_encoder_7_3 dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .message  (message),
    .busy     (busy),
    .valid    (valid),
    .codeword (codeword)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived codewords for the unit messages m2=1, m1=1, m0=1.
  localparam logic [20:0] B2 = 21'h40C77;
  localparam logic [20:0] B1 = 21'h0886D;
  localparam logic [20:0] B0 = 21'h01653;

  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] acc, x;
    acc = 3'd0;
    x   = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[2] ? ({x[1:0], 1'b0} ^ 3'b011) : {x[1:0], 1'b0};
    end
    return acc;
  endfunction

  // Reference encoder built from the unit codewords by linearity.
  function automatic logic [20:0] enc_model(input logic [8:0] m);
    logic [20:0] b2, b1, b0, cw;
    b2 = B2; b1 = B1; b0 = B0;
    cw = '0;
    for (int i = 0; i < 7; i++) begin
      cw[3*i +: 3] = gf_mul(m[8:6], b2[3*i +: 3]) ^ gf_mul(m[5:3], b1[3*i +: 3]) ^ gf_mul(m[2:0], b0[3*i +: 3]);
    end
    return cw;
  endfunction

  // Evaluate the codeword polynomial at alpha^j.
  function automatic logic [2:0] syn(input logic [20:0] cw, input int j);
    logic [2:0] root, s, sym;
    root = 3'd1;
    for (int k = 0; k < j; k++) root = gf_mul(root, 3'd2);
    s = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      sym = cw[3*i +: 3];
      s = gf_mul(s, root) ^ sym;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One enable pulse, then watch 8 cycles; optionally disturb message/enable while busy.
  task automatic do_encode(input logic [8:0] m, input bit meddle, output logic [20:0] cw,
                           output int vcnt, output int vat, output int bcnt);
    message = m;
    enable  = 1'b1;
    vcnt = 0; vat = 0; bcnt = 0; cw = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bcnt += int'(busy);
      if (valid) begin
        vcnt++;
        vat = c;
        cw  = codeword;
      end
      if (meddle && c <= 2) begin
        message = 9'h1FF;
        enable  = 1'b1;
      end else begin
        enable = 1'b0;
      end
    end
  endtask

  initial begin
    logic [20:0] cw, cw_a, cw_b, cw_c;
    int vcnt, vat, bcnt, vsum;
    logic vbefore;

    reset = 1'b1; enable = 1'b0; message = '0;

    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cw", codeword, 0);
    vsum = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vsum += int'(valid);
    end
    chk("idle_no_valid", vsum, 0);

    // Single symbol
    do_encode(9'h001, 1'b0, cw, vcnt, vat, bcnt);
    $display("[TB] single msg=001 cw=%h valid_cnt=%0d at=%0d busy=%0d", cw, vcnt, vat, bcnt);
    chk("single_cw", cw, 21'h01653);
    chk("single_vcnt", vcnt, 1);
    chk("single_vat", vat, 4);
    chk("single_busy", bcnt, 3);
    chk("single_hold", codeword, 21'h01653);

    // Hold/ignore while busy
    do_encode(9'h001, 1'b1, cw, vcnt, vat, bcnt);
    $display("[TB] hold msg=001 cw=%h valid_cnt=%0d at=%0d", cw, vcnt, vat);
    chk("hold_cw", cw, 21'h01653);
    chk("hold_vcnt", vcnt, 1);
    chk("hold_vat", vat, 4);
    message = 9'h000;

    // Reset on the second shift edge
    message = 9'h0AB; enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_cw", codeword, 0);
    vsum = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vsum += int'(valid);
    end
    chk("midrst_no_valid", vsum, 0);
    $display("[TB] mid-encode reset cw=%h valids=%0d", codeword, vsum);
    do_encode(9'h001, 1'b0, cw, vcnt, vat, bcnt);
    $display("[TB] after reset msg=001 cw=%h", cw);
    chk("fresh_cw", cw, 21'h01653);
    chk("fresh_vat", vat, 4);

    // Reset and enable together
    reset = 1'b1; enable = 1'b1; message = 9'h1FF;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    chk("rst_en_busy", busy, 0);
    vsum = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vsum += int'(valid) + int'(busy);
    end
    chk("rst_en_idle", vsum, 0);
    $display("[TB] reset+enable busy/valid activity=%0d", vsum);

    // Linearity
    do_encode(9'h1A5, 1'b0, cw_a, vcnt, vat, bcnt);
    chk("lin_a", cw_a, enc_model(9'h1A5));
    do_encode(9'h0C3, 1'b0, cw_b, vcnt, vat, bcnt);
    chk("lin_b", cw_b, enc_model(9'h0C3));
    do_encode(9'h166, 1'b0, cw_c, vcnt, vat, bcnt);
    chk("lin_c", cw_c, enc_model(9'h166));
    chk("lin_xor", cw_a ^ cw_b, cw_c);
    $display("[TB] linearity %h ^ %h vs %h", cw_a, cw_b, cw_c);

    // Exhaustive, back-to-back with enable held high
    message = 9'h000; enable = 1'b1;
    for (int i = 0; i < 512; i++) begin
      vbefore = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) vbefore = vbefore | valid;
      end
      cw = codeword;
      chk("bb_valid", {vbefore, valid, busy}, 3'b010);
      chk("bb_cw", cw, enc_model(i[8:0]));
      chk("bb_synd", {syn(cw, 1), syn(cw, 2), syn(cw, 3), syn(cw, 4)}, 12'h000);
      if (i == 0) chk("bb_zero", cw, 21'h000000);
      $display("[TB] msg=%h cw=%h", i[8:0], cw);
      if (i == 511) enable = 1'b0;
      else message = 9'(i + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
